// File: rtl/id_ex_stage_pkg.sv
// Shared opcode encodings and constants for the decode->execute boundary.
//   ALU op codes (alu_op_e), operand-select constants for A/B muxes,
//   and the writeback snoop hit test used by every pipeline entry.
package id_ex_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_SUB  = 4'd12,
    ALU_SRA  = 4'd13,
    ALU_BSEL = 4'd15
  } alu_op_e;

  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  // x0 is hardwired to zero, so a writeback to it never forwards.
  function automatic logic fwd_hit(input logic                  wen,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return wen && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_entry.sv
// ex_entry_reg: one pipeline entry (valid bit, rs1/rs2 addr+data, opaque payload).
//   i_load       capture i_ld_* this cycle
//   i_valid_d    next value of the valid bit (computed by the owner)
//   i_ld_*       load source fields
//   i_fwd_*      writeback snoop bus
//   o_*          stored fields; o_rsN_data reflects all forwarding so far
// Forwarding is applied to whichever source is being written this cycle:
// the load source when loading, else the held value while valid.
module ex_entry_reg
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PAY_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_valid_d,
  input  logic [REG_ADDR_W-1:0] i_ld_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_ld_rs2_addr,
  input  logic [WIDTH-1:0]      i_ld_rs1_data,
  input  logic [WIDTH-1:0]      i_ld_rs2_data,
  input  logic [PAY_W-1:0]      i_ld_pay,
  input  logic                  i_fwd_wen,
  input  logic [REG_ADDR_W-1:0] i_fwd_rd,
  input  logic [WIDTH-1:0]      i_fwd_data,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_rs1_addr,
  output logic [REG_ADDR_W-1:0] o_rs2_addr,
  output logic [WIDTH-1:0]      o_rs1_data,
  output logic [WIDTH-1:0]      o_rs2_data,
  output logic [PAY_W-1:0]      o_pay
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs1_addr, r_rs2_addr;
  logic [WIDTH-1:0]      r_rs1_data, r_rs2_data;
  logic [PAY_W-1:0]      r_pay;

  logic [REG_ADDR_W-1:0] w_src_rs1_addr, w_src_rs2_addr;
  logic [WIDTH-1:0]      w_src_rs1_data, w_src_rs2_data;
  logic [WIDTH-1:0]      w_rs1_next, w_rs2_next;

  always_comb begin
    w_src_rs1_addr = i_load ? i_ld_rs1_addr : r_rs1_addr;
    w_src_rs2_addr = i_load ? i_ld_rs2_addr : r_rs2_addr;
    w_src_rs1_data = i_load ? i_ld_rs1_data : r_rs1_data;
    w_src_rs2_data = i_load ? i_ld_rs2_data : r_rs2_data;
    w_rs1_next = fwd_hit(i_fwd_wen, i_fwd_rd, w_src_rs1_addr) ? i_fwd_data : w_src_rs1_data;
    w_rs2_next = fwd_hit(i_fwd_wen, i_fwd_rd, w_src_rs2_addr) ? i_fwd_data : w_src_rs2_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_pay      <= '0;
    end else begin
      r_valid <= i_valid_d;
      if (i_load) begin
        r_rs1_addr <= i_ld_rs1_addr;
        r_rs2_addr <= i_ld_rs2_addr;
        r_pay      <= i_ld_pay;
      end
      if (i_load || r_valid) begin
        r_rs1_data <= w_rs1_next;
        r_rs2_data <= w_rs2_next;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_rs1_addr = r_rs1_addr;
  assign o_rs2_addr = r_rs2_addr;
  assign o_rs1_data = r_rs1_data;
  assign o_rs2_data = r_rs2_data;
  assign o_pay      = r_pay;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute stage feeding the ALU.
//   in_*      decoded instruction with valid/ready handshake
//   flush     drop everything held and incoming
//   fwd_*     writeback snoop bus, forwarded into captured/held rs values
//   out_*     head entry with valid/ready handshake
//   alu_a/b   operand muxes from the head; alu_sel/comp_un pass through
// Two-entry skid buffer: HEAD drives outputs, SKID catches one instruction
// under backpressure. in_ready depends only on the SKID valid register.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_pc,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [WIDTH-1:0]      in_rs1_data,
  input  logic [WIDTH-1:0]      in_rs2_data,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  in_asel,
  input  logic                  in_bsel,
  input  logic [ALU_OP_W-1:0]   in_alu_sel,
  input  logic                  in_comp_un,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_wen,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  flush,
  input  logic                  fwd_wen,
  input  logic [REG_ADDR_W-1:0] fwd_rd,
  input  logic [WIDTH-1:0]      fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [ALU_OP_W-1:0]   alu_sel,
  output logic                  comp_un,
  output logic [WIDTH-1:0]      out_pc,
  output logic [WIDTH-1:0]      out_rs2_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_wen,
  output logic [CTRL_W-1:0]     out_ctrl
);

  localparam int unsigned PAY_W = 2*WIDTH + 1 + 1 + ALU_OP_W + 1 + REG_ADDR_W + 1 + CTRL_W;

  logic                  w_head_valid, w_skid_valid;
  logic                  w_head_load, w_skid_load;
  logic                  w_head_valid_d, w_skid_valid_d;
  logic                  w_accept, w_drain, w_head_from_skid;

  logic [PAY_W-1:0]      w_in_pay, w_skid_pay, w_head_pay, w_head_ld_pay;
  logic [REG_ADDR_W-1:0] w_s_rs1_addr, w_s_rs2_addr, w_h_rs1_addr, w_h_rs2_addr;
  logic [WIDTH-1:0]      w_s_rs1_data, w_s_rs2_data, w_h_rs1_data, w_h_rs2_data;
  logic [REG_ADDR_W-1:0] w_head_ld_rs1_addr, w_head_ld_rs2_addr;
  logic [WIDTH-1:0]      w_head_ld_rs1_data, w_head_ld_rs2_data;

  logic [WIDTH-1:0]      w_h_pc, w_h_imm;
  logic                  w_h_asel, w_h_bsel;

  assign w_in_pay = {in_pc, in_imm, in_asel, in_bsel, in_alu_sel, in_comp_un,
                     in_rd_addr, in_reg_wen, in_ctrl};

  assign in_ready = ~w_skid_valid;

  always_comb begin
    w_accept         = in_valid & ~w_skid_valid;
    w_drain          = w_head_valid & out_ready;
    w_head_from_skid = w_drain & w_skid_valid;
    w_head_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_head_valid_d   = w_head_valid;
    w_skid_valid_d   = w_skid_valid;
    if (flush) begin
      w_head_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else begin
      // A full SKID forces in_ready low, so a SKID->HEAD move never
      // coincides with an accept.
      if (w_head_from_skid) begin
        w_head_load    = 1'b1;
        w_head_valid_d = 1'b1;
        w_skid_valid_d = 1'b0;
      end else if (w_accept && (!w_head_valid || w_drain)) begin
        w_head_load    = 1'b1;
        w_head_valid_d = 1'b1;
      end else if (w_drain) begin
        w_head_valid_d = 1'b0;
      end
      if (w_accept && w_head_valid && !w_drain) begin
        w_skid_load    = 1'b1;
        w_skid_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_head_ld_rs1_addr = w_head_from_skid ? w_s_rs1_addr : in_rs1_addr;
    w_head_ld_rs2_addr = w_head_from_skid ? w_s_rs2_addr : in_rs2_addr;
    w_head_ld_rs1_data = w_head_from_skid ? w_s_rs1_data : in_rs1_data;
    w_head_ld_rs2_data = w_head_from_skid ? w_s_rs2_data : in_rs2_data;
    w_head_ld_pay      = w_head_from_skid ? w_skid_pay   : w_in_pay;
  end

  ex_entry_reg #(.WIDTH(WIDTH), .PAY_W(PAY_W)) u_skid (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_skid_load),
    .i_valid_d     (w_skid_valid_d),
    .i_ld_rs1_addr (in_rs1_addr),
    .i_ld_rs2_addr (in_rs2_addr),
    .i_ld_rs1_data (in_rs1_data),
    .i_ld_rs2_data (in_rs2_data),
    .i_ld_pay      (w_in_pay),
    .i_fwd_wen     (fwd_wen),
    .i_fwd_rd      (fwd_rd),
    .i_fwd_data    (fwd_data),
    .o_valid       (w_skid_valid),
    .o_rs1_addr    (w_s_rs1_addr),
    .o_rs2_addr    (w_s_rs2_addr),
    .o_rs1_data    (w_s_rs1_data),
    .o_rs2_data    (w_s_rs2_data),
    .o_pay         (w_skid_pay)
  );

  ex_entry_reg #(.WIDTH(WIDTH), .PAY_W(PAY_W)) u_head (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_head_load),
    .i_valid_d     (w_head_valid_d),
    .i_ld_rs1_addr (w_head_ld_rs1_addr),
    .i_ld_rs2_addr (w_head_ld_rs2_addr),
    .i_ld_rs1_data (w_head_ld_rs1_data),
    .i_ld_rs2_data (w_head_ld_rs2_data),
    .i_ld_pay      (w_head_ld_pay),
    .i_fwd_wen     (fwd_wen),
    .i_fwd_rd      (fwd_rd),
    .i_fwd_data    (fwd_data),
    .o_valid       (w_head_valid),
    .o_rs1_addr    (w_h_rs1_addr),
    .o_rs2_addr    (w_h_rs2_addr),
    .o_rs1_data    (w_h_rs1_data),
    .o_rs2_data    (w_h_rs2_data),
    .o_pay         (w_head_pay)
  );

  assign {w_h_pc, w_h_imm, w_h_asel, w_h_bsel, alu_sel, comp_un,
          out_rd_addr, out_reg_wen, out_ctrl} = w_head_pay;

  assign out_valid    = w_head_valid;
  assign out_pc       = w_h_pc;
  assign out_rs2_data = w_h_rs2_data;
  assign alu_a        = (w_h_asel == ASEL_PC)  ? w_h_pc  : w_h_rs1_data;
  assign alu_b        = (w_h_bsel == BSEL_IMM) ? w_h_imm : w_h_rs2_data;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]    in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic          in_asel, in_bsel, in_comp_un, in_reg_wen;
  logic [3:0]    in_alu_sel;
  logic [CW-1:0] in_ctrl;
  logic          flush, fwd_wen;
  logic [4:0]    fwd_rd;
  logic [W-1:0]  fwd_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  alu_a, alu_b, out_pc, out_rs2_data;
  logic [3:0]    alu_sel;
  logic          comp_un, out_reg_wen;
  logic [4:0]    out_rd_addr;
  logic [CW-1:0] out_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_alu_sel(in_alu_sel),
    .in_comp_un(in_comp_un), .in_rd_addr(in_rd_addr), .in_reg_wen(in_reg_wen),
    .in_ctrl(in_ctrl), .flush(flush), .fwd_wen(fwd_wen), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .comp_un(comp_un),
    .out_pc(out_pc), .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr),
    .out_reg_wen(out_reg_wen), .out_ctrl(out_ctrl)
  );

  // Reference model: an ordered list of in-flight instructions (max 2).
  typedef struct {
    logic [W-1:0]  pc, rs1d, rs2d, imm;
    logic [4:0]    rs1a, rs2a, rd;
    logic          asel, bsel, cu, wen;
    logic [3:0]    sel;
    logic [CW-1:0] ctrl;
  } rec_t;
  rec_t q[$];

  function automatic logic hits(input logic [4:0] a);
    return fwd_wen && fwd_rd != 5'd0 && fwd_rd == a;
  endfunction

  function automatic rec_t incoming();
    rec_t r;
    r.pc = in_pc; r.imm = in_imm; r.rs1a = in_rs1_addr; r.rs2a = in_rs2_addr;
    r.rs1d = hits(in_rs1_addr) ? fwd_data : in_rs1_data;
    r.rs2d = hits(in_rs2_addr) ? fwd_data : in_rs2_data;
    r.rd = in_rd_addr; r.asel = in_asel; r.bsel = in_bsel; r.cu = in_comp_un;
    r.wen = in_reg_wen; r.sel = in_alu_sel; r.ctrl = in_ctrl;
    return r;
  endfunction

  task automatic model_update();
    int sz;
    sz = q.size();
    if (rst || flush) begin
      q.delete();
    end else begin
      foreach (q[i]) begin
        if (hits(q[i].rs1a)) q[i].rs1d = fwd_data;
        if (hits(q[i].rs2a)) q[i].rs2d = fwd_data;
      end
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) q.push_back(incoming());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_asel = 0; in_bsel = 0;
    in_alu_sel = '0; in_comp_un = 0; in_rd_addr = '0; in_reg_wen = 0; in_ctrl = '0;
    flush = 0; fwd_wen = 0; fwd_rd = '0; fwd_data = '0; out_ready = 0;
  endtask

  task automatic set_instr(input logic [W-1:0] pc, input logic [4:0] r1a,
                           input logic [W-1:0] r1d, input logic [4:0] r2a,
                           input logic [W-1:0] r2d, input logic [W-1:0] imm,
                           input logic as, input logic bs, input logic [3:0] sel);
    in_valid = 1; in_pc = pc; in_rs1_addr = r1a; in_rs1_data = r1d;
    in_rs2_addr = r2a; in_rs2_data = r2d; in_imm = imm; in_asel = as;
    in_bsel = bs; in_alu_sel = sel; in_rd_addr = 5'd1; in_reg_wen = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_checks++;
    if (alu_a !== '0 || alu_b !== '0) begin n_errors++; $display("FAIL reset_ops: got a=%0h b=%0h expected 0/0", alu_a, alu_b); end
    n_checks++;
    if (out_pc !== '0 || out_ctrl !== '0 || alu_sel !== '0) begin n_errors++; $display("FAIL reset_fields: got pc=%0h ctrl=%0h sel=%0h expected 0", out_pc, out_ctrl, alu_sel); end
    rst = 0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_pass();
    clear_inputs();
    out_ready = 1;
    set_instr(32'h8000_0000, 5'd2, 32'd5, 5'd0, 32'd0, 32'd7, ASEL_RS1, BSEL_IMM, ALU_ADD);
    tick();
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_sel !== ALU_ADD) begin
      n_errors++; $display("FAIL pass_ops: got v=%0b a=%0h b=%0h sel=%0h expected 1/5/7/0", out_valid, alu_a, alu_b, alu_sel);
    end
    n_checks++;
    if (out_pc !== 32'h8000_0000) begin n_errors++; $display("FAIL pass_pc: got %0h expected 80000000", out_pc); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL pass_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    set_instr(32'h100, 5'd1, 32'd11, 5'd2, 32'd22, 32'd0, ASEL_PC, BSEL_RS2, ALU_SUB);
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_pc !== 32'h100) begin n_errors++; $display("FAIL bp_i0: got rdy=%0b pc=%0h expected 1/100", in_ready, out_pc); end
    n_checks++;
    if (alu_a !== 32'h100 || alu_b !== 32'd22) begin n_errors++; $display("FAIL bp_i0_ops: got a=%0h b=%0h expected 100/16", alu_a, alu_b); end
    set_instr(32'h104, 5'd3, 32'd33, 5'd4, 32'd44, 32'd0, ASEL_RS1, BSEL_RS2, ALU_XOR);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h100) begin n_errors++; $display("FAIL bp_full: got rdy=%0b pc=%0h expected 0/100", in_ready, out_pc); end
    set_instr(32'h108, 5'd5, 32'd55, 5'd6, 32'd66, 32'd9, ASEL_RS1, BSEL_IMM, ALU_OR);
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h100 || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold: got rdy=%0b pc=%0h v=%0b expected 0/100/1", in_ready, out_pc, out_valid); end
    out_ready = 1;
    tick();
    n_checks++;
    if (out_pc !== 32'h104 || alu_a !== 32'd33 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_i1: got pc=%0h a=%0h rdy=%0b expected 104/21/1", out_pc, alu_a, in_ready); end
    tick();
    in_valid = 0;
    n_checks++;
    if (out_pc !== 32'h108 || alu_b !== 32'd9 || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_i2: got pc=%0h b=%0h v=%0b expected 108/9/1", out_pc, alu_b, out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_forward();
    clear_inputs();
    set_instr(32'h200, 5'd3, 32'd1, 5'd0, 32'd0, 32'd0, ASEL_RS1, BSEL_RS2, ALU_ADD);
    tick();
    // second instruction parks in SKID with rs2=x4
    set_instr(32'h204, 5'd0, 32'd0, 5'd4, 32'd2, 32'd0, ASEL_RS1, BSEL_RS2, ALU_ADD);
    tick();
    in_valid = 0;
    n_checks++;
    if (alu_a !== 32'd1) begin n_errors++; $display("FAIL fwd_before: got %0h expected 1", alu_a); end
    fwd_wen = 1; fwd_rd = 5'd3; fwd_data = 32'h55;
    tick();
    n_checks++;
    if (alu_a !== 32'h55) begin n_errors++; $display("FAIL fwd_head: got %0h expected 55", alu_a); end
    fwd_rd = 5'd0; fwd_data = 32'h99;
    tick();
    n_checks++;
    if (alu_a !== 32'h55) begin n_errors++; $display("FAIL fwd_x0: got %0h expected 55", alu_a); end
    fwd_rd = 5'd4; fwd_data = 32'h77; out_ready = 1;
    tick();
    fwd_wen = 0;
    n_checks++;
    if (out_pc !== 32'h204 || out_rs2_data !== 32'h77 || alu_b !== 32'h77) begin n_errors++; $display("FAIL fwd_skid_move: got pc=%0h rs2=%0h b=%0h expected 204/77/77", out_pc, out_rs2_data, alu_b); end
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    set_instr(32'h300, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, ASEL_RS1, BSEL_RS2, ALU_ADD);
    tick();
    set_instr(32'h304, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, ASEL_RS1, BSEL_RS2, ALU_ADD);
    tick();
    set_instr(32'h308, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, ASEL_RS1, BSEL_RS2, ALU_ADD);
    flush = 1; out_ready = 1;
    tick();
    flush = 0; in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_clear: got v=%0b rdy=%0b expected 0/1", out_valid, in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_drop: got v=%0b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [W-1:0] seq;
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    seq = 32'h1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if (out_valid !== (q.size() > 0)) begin n_errors++; $display("FAIL rnd_valid cyc %0d: got %0b expected %0b", cyc, out_valid, q.size() > 0); end
      n_checks++;
      if (in_ready !== (q.size() < 2)) begin n_errors++; $display("FAIL rnd_ready cyc %0d: got %0b expected %0b", cyc, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        n_checks++;
        if (out_pc !== q[0].pc) begin n_errors++; $display("FAIL rnd_pc cyc %0d: got %0h expected %0h", cyc, out_pc, q[0].pc); end
        n_checks++;
        if (alu_a !== (q[0].asel ? q[0].pc : q[0].rs1d)) begin n_errors++; $display("FAIL rnd_alu_a cyc %0d: got %0h expected %0h", cyc, alu_a, q[0].asel ? q[0].pc : q[0].rs1d); end
        n_checks++;
        if (alu_b !== (q[0].bsel ? q[0].imm : q[0].rs2d)) begin n_errors++; $display("FAIL rnd_alu_b cyc %0d: got %0h expected %0h", cyc, alu_b, q[0].bsel ? q[0].imm : q[0].rs2d); end
        n_checks++;
        if (out_rs2_data !== q[0].rs2d) begin n_errors++; $display("FAIL rnd_rs2 cyc %0d: got %0h expected %0h", cyc, out_rs2_data, q[0].rs2d); end
        n_checks++;
        if (alu_sel !== q[0].sel || comp_un !== q[0].cu || out_rd_addr !== q[0].rd ||
            out_reg_wen !== q[0].wen || out_ctrl !== q[0].ctrl) begin
          n_errors++;
          $display("FAIL rnd_ctrl cyc %0d: got sel=%0h cu=%0b rd=%0d wen=%0b ctrl=%0h expected %0h/%0b/%0d/%0b/%0h",
                   cyc, alu_sel, comp_un, out_rd_addr, out_reg_wen, out_ctrl,
                   q[0].sel, q[0].cu, q[0].rd, q[0].wen, q[0].ctrl);
        end
      end
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 39) == 0);
      fwd_wen     = $urandom_range(0, 1);
      fwd_rd      = 5'($urandom_range(0, 7));
      fwd_data    = $urandom;
      in_pc       = seq;
      in_rs1_addr = 5'($urandom_range(0, 7));
      in_rs2_addr = 5'($urandom_range(0, 7));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_asel     = $urandom_range(0, 1);
      in_bsel     = $urandom_range(0, 1);
      in_alu_sel  = 4'($urandom);
      in_comp_un  = $urandom_range(0, 1);
      in_rd_addr  = 5'($urandom);
      in_reg_wen  = $urandom_range(0, 1);
      in_ctrl     = 8'($urandom);
      tick();
      seq = seq + 32'd4;
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_backpressure();
    test_forward();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
